lcd1602_row_driver: RTL and testbench



---
 rtl/lcd_pkg.sv | 37 +++
 rtl/lcd_xfer.sv | 89 ++++++++
 rtl/lcd1602_row_driver.sv | 173 +++++++++++++++++
 tb/tb_lcd1602_row_driver.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD1602 row driver.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_INIT,
    ST_ADDR1,
    ST_ROW1,
    ST_ADDR2,
    ST_ROW2
  } state_t;

  // PH_IDLE only occurs before the first transfer; afterwards transfers run back to back
  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_PULSE,
    PH_HOLD
  } phase_t;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_LINE1    = 8'h80;
  localparam logic [7:0] CMD_LINE2    = 8'hC0;

  function automatic int unsigned umax(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // character idx of a row; character 0 sits in the top byte
  function automatic logic [7:0] row_byte(input logic [127:0] row, input logic [3:0] idx);
    return row[8*(15 - int'(idx)) +: 8];
  endfunction

endpackage

// File: rtl/lcd_xfer.sv
// Single-byte LCD write engine: SETUP (1 cycle), PULSE (E high), HOLD (wait cycles).
// A new byte is accepted while idle or in the last HOLD cycle so transfers abut.
module lcd_xfer
  import lcd_pkg::*;
#(
  parameter int unsigned E_PULSE_CYC = 5,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             start,
  input  logic             rs,
  input  logic [7:0]       data,
  input  logic [CNT_W-1:0] wait_cyc,
  output logic             accept,
  output logic             done,
  output logic             lcd_en,
  output logic             lcd_rs,
  output logic [7:0]       lcd_data
);

  phase_t           phase, phase_n;
  logic [CNT_W-1:0] cnt, cnt_n, wait_q;
  logic             rs_q;
  logic [7:0]       data_q;

  // phase/counter register and the byte captured when a transfer is accepted
  always_ff @(posedge clk) begin
    if (!nRst) begin
      phase  <= PH_IDLE;
      cnt    <= '0;
      wait_q <= '0;
      rs_q   <= 1'b0;
      data_q <= '0;
    end else begin
      phase <= phase_n;
      cnt   <= cnt_n;
      if (accept) begin
        rs_q   <= rs;
        data_q <= data;
        wait_q <= wait_cyc;
      end
    end
  end

  // next phase; done marks the final HOLD cycle, counter clears on every phase change
  always_comb begin
    done    = (phase == PH_HOLD) && ((cnt + CNT_W'(1)) >= wait_q);
    accept  = start && ((phase == PH_IDLE) || done);
    phase_n = phase;
    cnt_n   = cnt;
    if (accept) begin
      phase_n = PH_SETUP;
      cnt_n   = '0;
    end else begin
      case (phase)
        PH_SETUP: begin
          phase_n = PH_PULSE;
          cnt_n   = '0;
        end
        PH_PULSE: begin
          if (cnt == CNT_W'(E_PULSE_CYC - 1)) begin
            phase_n = PH_HOLD;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        PH_HOLD: begin
          if (done) begin
            phase_n = PH_IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // bus outputs: rs/data held from SETUP until the next accepted byte
  always_comb begin
    lcd_en   = (phase == PH_PULSE);
    lcd_rs   = rs_q;
    lcd_data = data_q;
  end

endmodule

// File: rtl/lcd1602_row_driver.sv
// 16x2 HD44780 driver: power-up wait, init commands, then continuous refresh of
// both lines from per-frame snapshots of row1/row2.
// Optional: LCD_ASCII_FILTER_EN replaces non-printable characters with spaces.
module lcd1602_row_driver
  import lcd_pkg::*;
#(
  parameter int unsigned POWERUP_CYC    = 150000,
  parameter int unsigned E_PULSE_CYC    = 5,
  parameter int unsigned CMD_WAIT_CYC   = 500,
  parameter int unsigned CLEAR_WAIT_CYC = 20000
) (
  input  logic         clk,
  input  logic         nRst,
  input  logic [127:0] row1,
  input  logic [127:0] row2,
  output logic         lcd_en,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic [7:0]   lcd_data,
  output logic         init_done,
  output logic         frame_done
);

  localparam int unsigned CNT_W = $clog2(umax(POWERUP_CYC, CLEAR_WAIT_CYC) + 1);

  state_t           state, state_n;
  logic [3:0]       idx, idx_n;
  logic [CNT_W-1:0] pwr_cnt, pwr_cnt_n;
  logic [127:0]     snap1, snap2;
  logic             start, x_rs, accept, done;
  logic [7:0]       x_byte;
  logic [CNT_W-1:0] x_wait;
  logic             tag_init_last, tag_frame_last;

  function automatic logic [7:0] shown(input logic [7:0] c);
`ifdef LCD_ASCII_FILTER_EN
    return ((c < 8'h20) || (c > 8'h7E)) ? 8'h20 : c;
`else
    return c;
`endif
  endfunction

  // state register
  always_ff @(posedge clk) begin
    if (!nRst) begin
      state   <= ST_POWERUP;
      idx     <= '0;
      pwr_cnt <= '0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      pwr_cnt <= pwr_cnt_n;
    end
  end

  // The FSM names the next byte to hand over, so it runs one transfer ahead of the bus;
  // tags remember which in-flight byte ends init or a frame for the status flags.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      snap1          <= '0;
      snap2          <= '0;
      tag_init_last  <= 1'b0;
      tag_frame_last <= 1'b0;
      init_done      <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      if (accept && (state == ST_ADDR1)) begin
        snap1 <= row1;
        snap2 <= row2;
      end
      if (accept) begin
        tag_init_last  <= (state == ST_INIT) && (idx == 4'd3);
        tag_frame_last <= (state == ST_ROW2) && (idx == 4'd15);
      end
      if (done && tag_init_last) init_done <= 1'b1;
      frame_done <= done && tag_frame_last;
    end
  end

  // next-state: advance whenever the transfer engine accepts the current byte
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    pwr_cnt_n = pwr_cnt;
    case (state)
      ST_POWERUP: begin
        if (pwr_cnt == CNT_W'(POWERUP_CYC - 1)) begin
          state_n   = ST_INIT;
          pwr_cnt_n = '0;
        end else begin
          pwr_cnt_n = pwr_cnt + CNT_W'(1);
        end
      end
      ST_INIT: begin
        if (accept) begin
          idx_n = idx + 4'd1;
          if (idx == 4'd3) begin
            state_n = ST_ADDR1;
            idx_n   = '0;
          end
        end
      end
      ST_ADDR1: if (accept) state_n = ST_ROW1;
      ST_ROW1: begin
        if (accept) begin
          idx_n = idx + 4'd1;
          if (idx == 4'd15) state_n = ST_ADDR2;
        end
      end
      ST_ADDR2: if (accept) state_n = ST_ROW2;
      ST_ROW2: begin
        if (accept) begin
          idx_n = idx + 4'd1;
          if (idx == 4'd15) state_n = ST_ADDR1;
        end
      end
      default: state_n = ST_POWERUP;
    endcase
  end

  // output decode: byte, register select and hold time for the current item
  always_comb begin
    start  = 1'b1;
    x_rs   = 1'b0;
    x_byte = CMD_FUNC_SET;
    x_wait = CNT_W'(CMD_WAIT_CYC);
    case (state)
      ST_POWERUP: start = 1'b0;
      ST_INIT: begin
        case (idx)
          4'd0: x_byte = CMD_FUNC_SET;
          4'd1: x_byte = CMD_DISP_ON;
          4'd2: begin
            x_byte = CMD_CLEAR;
            x_wait = CNT_W'(CLEAR_WAIT_CYC);
          end
          default: x_byte = CMD_ENTRY;
        endcase
      end
      ST_ADDR1: x_byte = CMD_LINE1;
      ST_ROW1: begin
        x_rs   = 1'b1;
        x_byte = shown(row_byte(snap1, idx));
      end
      ST_ADDR2: x_byte = CMD_LINE2;
      ST_ROW2: begin
        x_rs   = 1'b1;
        x_byte = shown(row_byte(snap2, idx));
      end
      default: start = 1'b0;
    endcase
  end

  assign lcd_rw = 1'b0;

  lcd_xfer #(
    .E_PULSE_CYC(E_PULSE_CYC),
    .CNT_W      (CNT_W)
  ) u_xfer (
    .clk     (clk),
    .nRst    (nRst),
    .start   (start),
    .rs      (x_rs),
    .data    (x_byte),
    .wait_cyc(x_wait),
    .accept  (accept),
    .done    (done),
    .lcd_en  (lcd_en),
    .lcd_rs  (lcd_rs),
    .lcd_data(lcd_data)
  );

endmodule

// File: tb/tb_lcd1602_row_driver.sv
// Self-checking bench for lcd1602_row_driver (small timing parameters).
module tb_lcd1602_row_driver;

  localparam int unsigned PC  = 10;
  localparam int unsigned EP  = 2;
  localparam int unsigned CW  = 4;
  localparam int unsigned CLW = 8;
  localparam int unsigned FRAME_CYC = 34 * (1 + EP + CW);

  logic         clk = 1'b0;
  logic         nRst = 1'b0;
  logic [127:0] row1 = '0;
  logic [127:0] row2 = '0;
  logic         lcd_en, lcd_rs, lcd_rw, init_done, frame_done;
  logic [7:0]   lcd_data;

  int unsigned    errors = 0;
  int unsigned    checks = 0;
  longint unsigned cyc = 0;
  int unsigned    fd_cycles = 0;
  int unsigned    frames_done = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (frame_done === 1'b1) fd_cycles <= fd_cycles + 1;

  lcd1602_row_driver #(
    .POWERUP_CYC   (PC),
    .E_PULSE_CYC   (EP),
    .CMD_WAIT_CYC  (CW),
    .CLEAR_WAIT_CYC(CLW)
  ) dut (
    .clk       (clk),
    .nRst      (nRst),
    .row1      (row1),
    .row2      (row2),
    .lcd_en    (lcd_en),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_data  (lcd_data),
    .init_done (init_done),
    .frame_done(frame_done)
  );

  typedef struct {
    logic        rs;
    logic [7:0]  data;
    int unsigned low;
  } xfer_t;

  typedef struct {
    logic [127:0] r1;
    logic [127:0] r2;
    logic         fixed;
    logic [7:0]   exp0;
    logic [7:0]   exp7;
  } rows_t;

  xfer_t init_tab[4];
  rows_t tab[8];

  // captured transfer
  logic        x_rs = 1'b0;
  logic [7:0]  x_data = '0;
  int unsigned x_low, x_high;
  logic        x_fd, x_hold_ok;
  longint unsigned x_start;
  longint unsigned prev80 = 0;
  logic        prev80_valid = 1'b0;
  logic [7:0]  got1[16];

  task automatic summary_and_finish();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // what the display should receive for character i of a row
  function automatic logic [7:0] model_char(input logic [127:0] r, input int i);
    logic [7:0] b;
    b = 8'(r >> (8 * (15 - i)));
`ifdef LCD_ASCII_FILTER_EN
    if (b < 8'h20 || b > 8'h7E) b = 8'h20;
`endif
    return b;
  endfunction

  // Called on a negedge sample; returns on the first low sample after the next enable pulse.
  task automatic next_xfer();
    int unsigned n = 0;
    logic pend = 1'b0;
    x_low = 0; x_fd = 1'b0; x_hold_ok = 1'b1;
    while (lcd_en !== 1'b1) begin
      if (pend) x_hold_ok = 1'b0;
      pend = (lcd_rs !== x_rs) || (lcd_data !== x_data);
      x_fd = frame_done;
      x_low++;
      n++;
      if (n > 500) begin
        check("xfer timeout", 1'b0, 1'b1);
        summary_and_finish();
      end
      @(negedge clk);
    end
    x_rs = lcd_rs; x_data = lcd_data; x_high = 0; x_start = cyc;
    while (lcd_en === 1'b1 && x_high < 100) begin
      x_high++;
      @(negedge clk);
      if (lcd_en === 1'b1 && (lcd_rs !== x_rs || lcd_data !== x_data)) x_hold_ok = 1'b0;
    end
  endtask

  task automatic expect_xfer(input string name, input logic rs, input logic [7:0] d, input int unsigned low);
    next_xfer();
    check($sformatf("%s rs", name), x_rs, rs);
    check($sformatf("%s data", name), x_data, d);
    check($sformatf("%s en width", name), x_high, EP);
    check($sformatf("%s low gap", name), x_low, low);
    check($sformatf("%s bus stable", name), x_hold_ok, 1'b1);
  endtask

  task automatic run_init();
    for (int i = 0; i < 4; i++) begin
      next_xfer();
      if (i == 0) check("powerup idle", (x_low >= PC + 1) && (x_low <= PC + 2), 1'b1);
      else        check($sformatf("init%0d low gap", i), x_low, init_tab[i].low);
      check($sformatf("init%0d rs", i), x_rs, init_tab[i].rs);
      check($sformatf("init%0d data", i), x_data, init_tab[i].data);
      check($sformatf("init%0d en width", i), x_high, EP);
      check($sformatf("init%0d bus stable", i), x_hold_ok, 1'b1);
      check($sformatf("init%0d init_done low", i), init_done, 1'b0);
    end
  endtask

  task automatic start_frame(input logic fd_exp);
    expect_xfer("line1 cmd", 1'b0, 8'h80, CW + 1);
    check("frame_done before line1", x_fd, fd_exp);
    check("init_done held", init_done, 1'b1);
    check("lcd_rw", lcd_rw, 1'b0);
    if (prev80_valid) check("frame length", x_start - prev80, FRAME_CYC);
    prev80 = x_start; prev80_valid = 1'b1;
  endtask

  task automatic row1_and_line2(input int k, input int nk);
    for (int i = 0; i < 16; i++) begin
      expect_xfer($sformatf("f%0d row1[%0d]", k, i), 1'b1, model_char(tab[k].r1, i), CW + 1);
      got1[i] = x_data;
      if (i == 4) begin
        row1 = tab[nk].r1;
        row2 = tab[nk].r2;
      end
    end
    expect_xfer("line2 cmd", 1'b0, 8'hC0, CW + 1);
  endtask

  // expected frame contents come from the rows present when the frame began
  task automatic expect_frame(input int k, input int nk, input logic fd_exp);
    start_frame(fd_exp);
    row1_and_line2(k, nk);
    for (int i = 0; i < 16; i++)
      expect_xfer($sformatf("f%0d row2[%0d]", k, i), 1'b1, model_char(tab[k].r2, i), CW + 1);
    if (tab[k].fixed) begin
      check($sformatf("f%0d char0", k), got1[0], tab[k].exp0);
      check($sformatf("f%0d char7", k), got1[7], tab[k].exp7);
    end
    frames_done++;
  endtask

  initial begin
    int unsigned n;
    init_tab = '{'{1'b0, 8'h38, 0}, '{1'b0, 8'h0C, CW + 1},
                 '{1'b0, 8'h01, CW + 1}, '{1'b0, 8'h06, CLW + 1}};
`ifdef LCD_ASCII_FILTER_EN
    tab[0] = '{"  HANGMAN GAME  ", "__________      ", 1'b1, 8'h20, 8'h41};
    tab[1] = '{"A HANGMAN GAME  ", "__________      ", 1'b1, 8'h41, 8'h41};
    tab[2] = '{{56'b0, 8'h45, 64'b0}, 128'h1F207E7F_80FF417E_20097A5B_7F7E2021, 1'b1, 8'h20, 8'h45};
    tab[3] = '{128'h1F207E7F_80FF417E_20097A5B_7F7E2021, '0, 1'b1, 8'h20, 8'h7E};
`else
    tab[0] = '{"  HANGMAN GAME  ", "__________      ", 1'b1, 8'h20, 8'h41};
    tab[1] = '{"A HANGMAN GAME  ", "__________      ", 1'b1, 8'h41, 8'h41};
    tab[2] = '{{56'b0, 8'h45, 64'b0}, 128'h1F207E7F_80FF417E_20097A5B_7F7E2021, 1'b1, 8'h00, 8'h45};
    tab[3] = '{128'h1F207E7F_80FF417E_20097A5B_7F7E2021, '0, 1'b1, 8'h1F, 8'h7E};
`endif
    for (int k = 4; k < 8; k++)
      tab[k] = '{{$urandom, $urandom, $urandom, $urandom},
                 {$urandom, $urandom, $urandom, $urandom}, 1'b0, 8'h00, 8'h00};

    row1 = tab[0].r1;
    row2 = tab[0].r2;
    repeat (3) @(negedge clk);
    check("reset lcd_en", lcd_en, 1'b0);
    check("reset lcd_rs", lcd_rs, 1'b0);
    check("reset lcd_rw", lcd_rw, 1'b0);
    check("reset lcd_data", lcd_data, 8'h00);
    check("reset init_done", init_done, 1'b0);
    check("reset frame_done", frame_done, 1'b0);
    nRst = 1'b1;
    run_init();

    for (int k = 0; k < 8; k++)
      expect_frame(k, (k < 7) ? k + 1 : 7, (k == 0) ? 1'b0 : 1'b1);

    // reset during the enable pulse of the first row2 character
    start_frame(1'b1);
    check("frame_done pulse count", fd_cycles, frames_done);
    row1_and_line2(7, 7);
    n = 0;
    while (lcd_en !== 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("row2[0] pulse seen", lcd_en, 1'b1);
    check("row2[0] data before reset", lcd_data, model_char(tab[7].r2, 0));
    nRst = 1'b0;
    @(negedge clk);
    check("mid reset lcd_en", lcd_en, 1'b0);
    check("mid reset init_done", init_done, 1'b0);
    check("mid reset frame_done", frame_done, 1'b0);
    check("mid reset lcd_data", lcd_data, 8'h00);
    check("mid reset lcd_rs", lcd_rs, 1'b0);
    @(negedge clk);
    nRst = 1'b1;
    x_rs = 1'b0; x_data = '0; prev80_valid = 1'b0;
    run_init();
    expect_frame(7, 7, 1'b0);

    summary_and_finish();
  end

endmodule
